// File: rtl/parity_response_checker.sv
// ============================================================================
// parity_response_checker : classifies parity-tester response packets (ODD/EVEN/ERROR)
// Rev 1.0
// ============================================================================
`default_nettype none

module parity_response_checker #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic             a_clk,
   input  logic             axis_aresetn,
   input  logic             axis_s_tvalid,
   input  logic [7:0]       axis_s_tdata,
   input  logic             axis_s_tlast,
   output logic             axis_s_tready,
   input  logic             cnt_clear,
   output logic             res_valid,
   output logic             res_odd,
   output logic             res_even,
   output logic             res_error,
   output logic             res_timeout,
   output logic [CNT_W-1:0] cnt_odd,
   output logic [CNT_W-1:0] cnt_even,
   output logic [CNT_W-1:0] cnt_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GOT_AB = 2'd1,
      ST_GOT_12 = 2'd2,
      ST_DRAIN  = 2'd3
   } state_t;

   localparam logic [TO_W-1:0]  c_to_last = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   state_t          r_state;
   logic [TO_W-1:0] r_to_cnt;

   state_t w_state_nxt;
   logic   w_beat;
   logic   w_odd;
   logic   w_even;
   logic   w_err;
   logic   w_timeout;

   assign w_beat = axis_s_tvalid & axis_s_tready;

   always_comb begin
      w_state_nxt = r_state;
      w_odd       = 1'b0;
      w_even      = 1'b0;
      w_err       = 1'b0;
      w_timeout   = 1'b0;
      if (w_beat) begin
         case (r_state)
            ST_IDLE: begin
               if (axis_s_tdata == 8'hFF) begin
                  if (axis_s_tlast) w_odd = 1'b1;
                  else              w_state_nxt = ST_DRAIN;
               end else if (axis_s_tdata == 8'hAB) begin
                  if (axis_s_tlast) w_err = 1'b1;
                  else              w_state_nxt = ST_GOT_AB;
               end else begin
                  if (axis_s_tlast) w_err = 1'b1;
                  else              w_state_nxt = ST_DRAIN;
               end
            end
            ST_GOT_AB: begin
               if (axis_s_tlast) begin
                  w_err       = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else if (axis_s_tdata == 8'h12) begin
                  w_state_nxt = ST_GOT_12;
               end else begin
                  w_state_nxt = ST_DRAIN;
               end
            end
            ST_GOT_12: begin
               if (axis_s_tlast) begin
                  w_even      = (axis_s_tdata == 8'hDE);
                  w_err       = (axis_s_tdata != 8'hDE);
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_DRAIN;
               end
            end
            default: begin
               if (axis_s_tlast) begin
                  w_err       = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         endcase
      end else if (TIMEOUT != 0 && r_state != ST_IDLE && r_to_cnt == c_to_last) begin
         // A beat on the same cycle takes precedence, so this only fires on an idle cycle.
         w_err       = 1'b1;
         w_timeout   = 1'b1;
         w_state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge a_clk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         r_state       <= ST_IDLE;
         r_to_cnt      <= '0;
         axis_s_tready <= 1'b0;
         res_valid     <= 1'b0;
         res_odd       <= 1'b0;
         res_even      <= 1'b0;
         res_error     <= 1'b0;
         res_timeout   <= 1'b0;
         cnt_odd       <= '0;
         cnt_even      <= '0;
         cnt_err       <= '0;
      end else begin
         axis_s_tready <= 1'b1;
         r_state       <= w_state_nxt;
         res_valid     <= w_odd | w_even | w_err;
         res_odd       <= w_odd;
         res_even      <= w_even;
         res_error     <= w_err;
         res_timeout   <= w_timeout;

         if (w_beat || w_timeout || r_state == ST_IDLE)
            r_to_cnt <= '0;
         else if (TIMEOUT != 0)
            r_to_cnt <= r_to_cnt + TO_W'(1);

         // Clear outranks a simultaneous increment; the verdict pulse is unaffected.
         if (cnt_clear) begin
            cnt_odd  <= '0;
            cnt_even <= '0;
            cnt_err  <= '0;
         end else begin
            if (w_odd && cnt_odd != c_cnt_max)   cnt_odd  <= cnt_odd + CNT_W'(1);
            if (w_even && cnt_even != c_cnt_max) cnt_even <= cnt_even + CNT_W'(1);
            if (w_err && cnt_err != c_cnt_max)   cnt_err  <= cnt_err + CNT_W'(1);
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_parity_response_checker.sv
// ============================================================================
// tb_parity_response_checker : vector table + scoreboard bench for the checker
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_parity_response_checker;

   localparam int TB_CNT_W = 2;
   localparam int TB_TO    = 4;
   localparam int CNT_MAX  = 3;
   localparam int NV       = 12;

   logic                a_clk = 1'b0;
   logic                axis_aresetn = 1'b1;
   logic                axis_s_tvalid = 1'b0;
   logic [7:0]          axis_s_tdata = 8'h00;
   logic                axis_s_tlast = 1'b0;
   logic                axis_s_tready;
   logic                cnt_clear = 1'b0;
   logic                res_valid, res_odd, res_even, res_error, res_timeout;
   logic [TB_CNT_W-1:0] cnt_odd, cnt_even, cnt_err;

   parity_response_checker #(.CNT_W(TB_CNT_W), .TIMEOUT(TB_TO), .TO_W(8)) dut (
      .a_clk        (a_clk),
      .axis_aresetn (axis_aresetn),
      .axis_s_tvalid(axis_s_tvalid),
      .axis_s_tdata (axis_s_tdata),
      .axis_s_tlast (axis_s_tlast),
      .axis_s_tready(axis_s_tready),
      .cnt_clear    (cnt_clear),
      .res_valid    (res_valid),
      .res_odd      (res_odd),
      .res_even     (res_even),
      .res_error    (res_error),
      .res_timeout  (res_timeout),
      .cnt_odd      (cnt_odd),
      .cnt_even     (cnt_even),
      .cnt_err      (cnt_err)
   );

   always #5 a_clk = ~a_clk;

   int   cyc = 0;
   logic clr_q = 1'b0;
   always @(posedge a_clk) begin
      cyc   <= cyc + 1;
      clr_q <= cnt_clear;
   end

   // f = {odd, even, err, timeout}
   typedef struct {
      logic [3:0] f;
      int         due;
   } exp_t;

   typedef struct {
      int              n;
      logic [0:4][7:0] b;
      int              gap;
      logic [3:0]      f;
   } vec_t;

   exp_t sb[$];
   vec_t vec[NV];
   int   checks = 0;
   int   errors = 0;
   int   m_odd = 0, m_even = 0, m_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input logic [3:0] f, input int due);
      exp_t e;
      e.f   = f;
      e.due = due;
      sb.push_back(e);
   endtask

   task automatic send(input logic [7:0] d, input logic l, input logic clr);
      axis_s_tvalid = 1'b1;
      axis_s_tdata  = d;
      axis_s_tlast  = l;
      cnt_clear     = clr;
      @(posedge a_clk);
      #1;
      axis_s_tvalid = 1'b0;
      axis_s_tlast  = 1'b0;
      cnt_clear     = 1'b0;
      axis_s_tdata  = 8'($urandom);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         axis_s_tdata = 8'($urandom);
         @(posedge a_clk);
         #1;
      end
   endtask

   function automatic int sat_inc(input int v);
      return (v < CNT_MAX) ? v + 1 : v;
   endfunction

   // Monitor / scoreboard: outputs sampled on the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge a_clk);
         if (!axis_aresetn) begin
            m_odd = 0; m_even = 0; m_err = 0;
            chk("reset_outputs", 32'({axis_s_tready, res_valid, res_odd, res_even, res_error,
                                       res_timeout, cnt_odd, cnt_even, cnt_err}), 32'd0);
         end else begin
            if (res_valid) begin
               if (sb.size() == 0) begin
                  chk("unexpected_verdict", 32'({res_odd, res_even, res_error, res_timeout}), 32'd0);
               end else begin
                  e = sb.pop_front();
                  chk("verdict_flags", 32'({res_odd, res_even, res_error, res_timeout}), 32'(e.f));
                  chk("verdict_latency", 32'(cyc), 32'(e.due));
                  if (e.f[3]) m_odd  = sat_inc(m_odd);
                  if (e.f[2]) m_even = sat_inc(m_even);
                  if (e.f[1]) m_err  = sat_inc(m_err);
               end
            end else begin
               chk("flags_idle", 32'({res_odd, res_even, res_error, res_timeout}), 32'd0);
               if (sb.size() > 0 && cyc > sb[0].due) begin
                  chk("missing_verdict", 32'd0, 32'(sb[0].f));
                  void'(sb.pop_front());
               end
            end
            if (clr_q) begin
               m_odd = 0; m_even = 0; m_err = 0;
            end
            chk("cnt_odd", 32'(cnt_odd), 32'(m_odd));
            chk("cnt_even", 32'(cnt_even), 32'(m_even));
            chk("cnt_err", 32'(cnt_err), 32'(m_err));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

   initial begin
      //            n  bytes            gap  {odd,even,err,to}
      vec[0]  = '{1, 40'hFF00000000, 0, 4'b1000};
      vec[1]  = '{3, 40'hAB12DE0000, 3, 4'b0100};  // gaps end on the timeout cycle: beat wins
      vec[2]  = '{4, 40'hAB13550000, 1, 4'b0010};
      vec[3]  = '{1, 40'hFF00000000, 0, 4'b1000};
      vec[4]  = '{1, 40'hAB00000000, 0, 4'b0010};
      vec[5]  = '{2, 40'hFF00000000, 0, 4'b0010};
      vec[6]  = '{3, 40'hAB12DF0000, 0, 4'b0010};
      vec[7]  = '{4, 40'hAB12DE0000, 0, 4'b0010};
      vec[8]  = '{1, 40'h1200000000, 0, 4'b0010};
      vec[9]  = '{4, 40'hABAB12DE00, 0, 4'b0010};
      vec[10] = '{3, 40'hAB12DE0000, 0, 4'b0100};
      vec[11] = '{2, 40'hFFFF000000, 2, 4'b0010};

      #1 axis_aresetn = 1'b0;
      #1 chk("reset_tready", 32'(axis_s_tready), 32'd0);
      chk("reset_valid", 32'(res_valid), 32'd0);
      repeat (3) @(posedge a_clk);
      #2 axis_aresetn = 1'b1;
      #1 chk("tready_before_edge", 32'(axis_s_tready), 32'd0);
      @(posedge a_clk);
      #1 chk("tready_after_release", 32'(axis_s_tready), 32'd1);

      for (int i = 0; i < NV; i++) begin
         for (int j = 0; j < vec[i].n; j++) begin
            if (j == vec[i].n - 1) push(vec[i].f, cyc + 1);
            send(vec[i].b[j], j == vec[i].n - 1, 1'b0);
            if (j < vec[i].n - 1) idle(vec[i].gap);
         end
      end
      idle(2);

      // Reset between 0x12 and 0xDE: partial packet abandoned.
      send(8'hAB, 1'b0, 1'b0);
      send(8'h12, 1'b0, 1'b0);
      #1 axis_aresetn = 1'b0;
      #1 chk("midreset_outputs", 32'({axis_s_tready, res_valid, cnt_odd, cnt_even, cnt_err}), 32'd0);
      @(posedge a_clk);
      #2 axis_aresetn = 1'b1;
      @(posedge a_clk);
      #1;
      push(4'b0010, cyc + 1);
      send(8'hDE, 1'b1, 1'b0);
      send(8'hAB, 1'b0, 1'b0);
      send(8'h12, 1'b0, 1'b0);
      push(4'b0100, cyc + 1);
      send(8'hDE, 1'b1, 1'b0);
      idle(2);

      // Timeout after 0xAB, then a fresh packet from IDLE.
      push(4'b0011, cyc + 1 + TB_TO);
      send(8'hAB, 1'b0, 1'b0);
      idle(TB_TO);
      push(4'b1000, cyc + 1);
      send(8'hFF, 1'b1, 1'b0);
      // Timeout while draining.
      push(4'b0011, cyc + 1 + TB_TO);
      send(8'hFF, 1'b0, 1'b0);
      idle(TB_TO + 2);

      // Saturation and clear-vs-increment.
      cnt_clear = 1'b1;
      @(posedge a_clk);
      #1 cnt_clear = 1'b0;
      for (int k = 0; k < 5; k++) begin
         push(4'b1000, cyc + 1);
         send(8'hFF, 1'b1, 1'b0);
      end
      idle(1);
      chk("cnt_odd_saturated", 32'(cnt_odd), 32'd3);
      push(4'b1000, cyc + 1);
      send(8'hFF, 1'b1, 1'b1);
      idle(1);
      chk("cnt_odd_cleared", 32'(cnt_odd), 32'd0);

      idle(8);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/parity_response_checker.md
Name: parity_response_checker

Overview:
- Downstream consumer of the parity tester's 8-bit AXI-Stream response.
- Classifies each response packet as ODD (single beat 0xFF), EVEN (three beats 0xAB, 0x12, 0xDE) or ERROR (anything else, including a stalled packet).
- Reports each verdict as a one-cycle pulse and keeps saturating per-class counters for status readout.
- Always-ready sink; malformed packets are drained to tlast so the checker never loses packet framing.

Parameters:
- CNT_W, 16, width of each verdict counter.
- TIMEOUT, 255, idle cycles allowed between beats inside a packet before ERROR; 0 disables the timeout.
- TO_W, 8, width of the timeout counter; TIMEOUT must be < 2^TO_W.

Ports:
- a_clk  input  1  clock; all logic on the rising edge.
- axis_aresetn  input  1  reset, asynchronous, active-low.
- axis_s_tvalid  input  1  upstream beat valid.
- axis_s_tdata  input  8  upstream beat data.
- axis_s_tlast  input  1  last beat of packet.
- axis_s_tready  output  1  sink ready.
- cnt_clear  input  1  synchronous clear of all counters.
- res_valid  output  1  one-cycle verdict pulse.
- res_odd  output  1  verdict is ODD; valid only with res_valid.
- res_even  output  1  verdict is EVEN; valid only with res_valid.
- res_error  output  1  verdict is ERROR; valid only with res_valid.
- res_timeout  output  1  ERROR was caused by timeout; valid only with res_valid.
- cnt_odd  output  CNT_W  number of ODD verdicts.
- cnt_even  output  CNT_W  number of EVEN verdicts.
- cnt_err  output  CNT_W  number of ERROR verdicts.

Behaviour:
- Reset (axis_aresetn=0, asynchronous): all outputs are 0, state is IDLE, timeout counter is 0.
- axis_s_tready is a register: 0 during reset, 1 from the first clock edge after release, and stays 1 thereafter.
- Beat accepted ("beat") when axis_s_tvalid & axis_s_tready.
- States: IDLE, GOT_AB, GOT_12, DRAIN. Transitions occur only on a beat, except for timeout.
- IDLE:
  - 0xFF & last: ODD verdict.
  - 0xFF & !last: go to DRAIN.
  - 0xAB & !last: go to GOT_AB.
  - 0xAB & last: ERROR.
  - Any other byte: ERROR if last, else go to DRAIN.
- GOT_AB:
  - 0x12 & !last: go to GOT_12.
  - Anything & last: ERROR, return to IDLE.
  - Other & !last: go to DRAIN.
- GOT_12:
  - 0xDE & last: EVEN verdict, return to IDLE.
  - Other & last: ERROR, return to IDLE.
  - Anything else & !last: go to DRAIN.
- DRAIN: discard beats; last: ERROR, return to IDLE.
- Verdict latency: res_valid and its flag assert on the cycle after the deciding beat's edge (registered), for exactly one cycle. Exactly one of res_odd/res_even/res_error is high with res_valid; all flags are 0 when res_valid is 0.
- Back-to-back packets: a new packet may start on the beat right after tlast; consecutive verdicts therefore produce consecutive res_valid pulses.
- Timeout counter:
  - Counts only in GOT_AB, GOT_12 and DRAIN, on cycles with no beat.
  - Cleared on every beat and in IDLE.
  - When it reaches TIMEOUT: ERROR verdict with res_timeout=1, state returns to IDLE, counter clears.
  - A late remainder of a timed-out packet is then parsed as a new packet from IDLE.
  - If a beat arrives in the same cycle the counter would reach TIMEOUT, the beat wins and the timeout does not fire.
- Counters:
  - Increment on the same edge as the matching res_valid assertion.
  - Saturate at 2^CNT_W-1; no wrap.
  - cnt_clear sets all three to 0 on the next edge and wins over a simultaneous increment. The verdict pulse itself is still emitted.
- Reset mid-packet: the partial packet is abandoned, no verdict is emitted, and counters return to 0.
- tdata is ignored while tvalid=0.

Test Plan:
- Single beat 0xFF with tlast -> one cycle later res_valid=1, res_odd=1; cnt_odd=1, others 0.
- Beats 0xAB, 0x12, 0xDE (tlast on 0xDE), with tvalid gaps of 3 cycles between beats, TIMEOUT=255 -> res_even=1 one cycle after the 0xDE beat; cnt_even=1.
- Beats 0xAB, 0x13, 0x55, 0x00 (tlast on 0x00) -> no verdict until the tlast beat, then res_error=1, res_timeout=0; cnt_err=1; a following 0xFF/tlast gives res_odd.
- 0xAB with no further beats, TIMEOUT=4 -> res_error=1 and res_timeout=1 exactly 4 cycles after the 0xAB beat; state IDLE, so a subsequent 0xFF/tlast gives res_odd.
- CNT_W=2, five ODD packets back-to-back -> cnt_odd=3 (saturated); cnt_clear pulsed together with a sixth ODD -> res_odd pulse seen, cnt_odd=0.
- axis_aresetn driven low asynchronously between 0x12 and 0xDE -> all outputs 0 immediately, tready=0; after release, 0xDE/tlast gives res_error, and 0xAB,0x12,0xDE gives res_even.
